// File: rtl/osd_cmd_tx_if.sv
// Request, staging-RAM and OSD-link signals grouped for osd_cmd_tx.
// The master side issues requests and serves RAM reads; the slave side is the transmitter.
interface osd_cmd_tx_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [3:0]  cmd_line;
   logic [8:0]  cmd_len;
   logic        rd_en;
   logic [11:0] rd_addr;
   logic [7:0]  rd_data;
   logic        io_osd;
   logic        io_strobe;
   logic [7:0]  io_dout;
   logic        busy;
   logic        done;

   modport master (
      output cmd_valid, cmd_op, cmd_line, cmd_len, rd_data,
      input  cmd_ready, rd_en, rd_addr, io_osd, io_strobe, io_dout, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_line, cmd_len, rd_data,
      output cmd_ready, rd_en, rd_addr, io_osd, io_strobe, io_dout, busy, done
   );
endinterface

// File: rtl/osd_cmd_tx.sv
// OSD command transmitter: turns enable/disable/write-line requests into
// io_osd / io_strobe / io_dout byte sequences, fetching payload from a staging RAM.
module osd_cmd_tx #(
   parameter int SETUP_CYC = 1,
   parameter int STROBE_HI = 2,
   parameter int STROBE_LO = 2,
   parameter int GAP_CYC   = 2
) (
   input logic          clk_sys,
   input logic          reset_n,
   osd_cmd_tx_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE, SETUP, HIGH, LOW, FETCH, CAP, TAIL
   } state_t;

   localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
   localparam logic [15:0] HI_LAST    = 16'(STROBE_HI - 1);
   localparam logic [15:0] LO_LAST    = 16'(STROBE_LO - 1);
   localparam logic [15:0] GAP_LAST   = 16'(GAP_CYC - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        isWrite_q, isWrite_d;
   logic [3:0]  line_q, line_d;
   logic [8:0]  nLeft_q, nLeft_d;
   logic [7:0]  idx_q, idx_d;
   logic [7:0]  dout_q, dout_d;
   logic        done_q, done_d;
   logic [7:0]  cmdByte;

   // State and datapath registers; reset drops the frame with no tail gap.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         isWrite_q <= 1'b0;
         line_q    <= '0;
         nLeft_q   <= '0;
         idx_q     <= '0;
         dout_q    <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         isWrite_q <= isWrite_d;
         line_q    <= line_d;
         nLeft_q   <= nLeft_d;
         idx_q     <= idx_d;
         dout_q    <= dout_d;
         done_q    <= done_d;
      end
   end

   // Reserved op 3 behaves as enable.
   always_comb begin
      case (bus.cmd_op)
         2'd0:    cmdByte = 8'h40;
         2'd2:    cmdByte = {4'h2, bus.cmd_line};
         default: cmdByte = 8'h41;
      endcase
   end

   // Next-state logic; cnt_q counts cycles spent in the current timed state.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 16'd1;
      isWrite_d = isWrite_q;
      line_d    = line_q;
      nLeft_d   = nLeft_q;
      idx_d     = idx_q;
      dout_d    = dout_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (bus.cmd_valid) begin
               isWrite_d = (bus.cmd_op == 2'd2);
               line_d    = bus.cmd_line;
               nLeft_d   = (bus.cmd_len > 9'd256) ? 9'd256 : bus.cmd_len;
               idx_d     = '0;
               dout_d    = cmdByte;
               state_d   = SETUP;
            end
         end
         SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               cnt_d   = '0;
               state_d = HIGH;
            end
         end
         HIGH: begin
            if (cnt_q == HI_LAST) begin
               cnt_d   = '0;
               state_d = LOW;
            end
         end
         LOW: begin
            if (cnt_q == LO_LAST) begin
               cnt_d   = '0;
               state_d = (isWrite_q && nLeft_q != 9'd0) ? FETCH : TAIL;
            end
         end
         FETCH: begin
            cnt_d   = '0;
            state_d = CAP;
         end
         CAP: begin
            cnt_d   = '0;
            dout_d  = bus.rd_data;
            idx_d   = idx_q + 8'd1;
            nLeft_d = nLeft_q - 9'd1;
            state_d = SETUP;
         end
         TAIL: begin
            dout_d = '0;
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decode from the registered state so a reset takes effect the next cycle.
   always_comb begin
      bus.cmd_ready = (state_q == IDLE) && reset_n;
      bus.busy      = (state_q != IDLE);
      bus.done      = done_q;
      bus.io_osd    = (state_q == SETUP) || (state_q == HIGH) || (state_q == LOW) ||
                      (state_q == FETCH) || (state_q == CAP);
      bus.io_strobe = (state_q == HIGH);
      bus.io_dout   = bus.io_osd ? dout_q : 8'h00;
      bus.rd_en     = (state_q == FETCH);
      bus.rd_addr   = (state_q == FETCH) ? {line_q, idx_q} : 12'h000;
   end

endmodule
